// File: rtl/pcm_i2s_tx_if.sv
// Sample stream from the PDM decimator into the I2S transmitter.
//   in_valid : single-cycle strobe, one per decimated sample
//   in_data  : signed PCM sample, qualified by in_valid
// master = decimator side (drives), slave = transmitter side (receives).
interface pcm_i2s_tx_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/pcm_i2s_tx.sv
// Philips I2S stereo transmitter for the microphone path. Buffers decimator
// samples in a small FIFO and sends each one duplicated on left and right.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   en          : transmitter enable; low returns the serialiser to idle and flushes
//   in_if       : sample stream (in_valid strobe, in_data sample)
//   clr_flags   : synchronous clear of the sticky flags (a same-cycle set wins)
//   bclk, lrclk : I2S bit clock and word select (0 = left)
//   sdata       : I2S serial data, MSB first, one bclk after the lrclk edge
//   fifo_level  : current FIFO occupancy
//   overflow    : sticky, a sample was dropped on a full FIFO
//   underflow   : sticky, a frame was sent with zeros
module pcm_i2s_tx #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned BCLK_DIV   = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  pcm_i2s_tx_if.slave                 in_if,
  input  logic                        clr_flags,
  output logic                        bclk,
  output logic                        lrclk,
  output logic                        sdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned FRAME_W = 2 * WIDTH;
  localparam int unsigned SLOT_W  = $clog2(FRAME_W);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0]   div_q,   div_d;
  logic               bclk_q,  bclk_d;
  logic [SLOT_W-1:0]  slot_q,  slot_d;
  logic               lrclk_q, lrclk_d;
  logic               sdata_q, sdata_d;
  logic [FRAME_W-1:0] sh_q,    sh_d;
  logic [AW-1:0]      wr_q,    wr_d;
  logic [AW-1:0]      rd_q,    rd_d;
  logic [LW-1:0]      cnt_q,   cnt_d;
  logic               ovf_q,   ovf_d;
  logic               udf_q,   udf_d;
  logic [WIDTH-1:0]   mem [FIFO_DEPTH];

  logic               tick;
  logic               fall;
  logic               pop_evt;
  logic               empty;
  logic               full;
  logic               do_pop;
  logic               do_push;
  logic [SLOT_W-1:0]  slot_nx;
  logic [FRAME_W-1:0] frame;

  // Bit-clock events and FIFO handshake decode
  always_comb begin
    tick    = (div_q == DIV_W'(BCLK_DIV - 1));
    fall    = en & tick & bclk_q;
    // Entering slot 1 is where a new frame word is fetched
    pop_evt = fall & (slot_q == '0);
    empty   = (cnt_q == '0);
    full    = (cnt_q == LW'(FIFO_DEPTH));
    do_pop  = pop_evt & ~empty;
    // A pop in the same cycle frees a full FIFO for the incoming sample
    do_push = en & in_if.in_valid & (~full | do_pop);
    slot_nx = (slot_q == SLOT_W'(FRAME_W - 1)) ? '0 : slot_q + SLOT_W'(1);
    frame   = do_pop ? {mem[rd_q], mem[rd_q]} : '0;
  end

  // Next-state logic for serialiser, FIFO pointers and flags
  always_comb begin
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    bclk_d  = tick ? ~bclk_q : bclk_q;
    slot_d  = slot_q;
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    sh_d    = sh_q;
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q + LW'(do_push) - LW'(do_pop);
    ovf_d   = (ovf_q & ~clr_flags) | (en & in_if.in_valid & full & ~do_pop);
    udf_d   = (udf_q & ~clr_flags) | (pop_evt & empty);

    if (fall) begin
      slot_d  = slot_nx;
      lrclk_d = (slot_nx >= SLOT_W'(WIDTH));
      // One-bit delay: bit 0 of the word trails into slot 0 of the next frame
      if (pop_evt) begin
        sdata_d = frame[FRAME_W-1];
        sh_d    = {frame[FRAME_W-2:0], 1'b0};
      end else begin
        sdata_d = sh_q[FRAME_W-1];
        sh_d    = {sh_q[FRAME_W-2:0], 1'b0};
      end
    end

    // Disabled: idle the serialiser and flush the FIFO, flags are kept
    if (!en) begin
      div_d   = '0;
      bclk_d  = 1'b0;
      slot_d  = SLOT_W'(FRAME_W - 1);
      lrclk_d = 1'b1;
      sdata_d = 1'b0;
      sh_d    = '0;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      slot_q  <= SLOT_W'(FRAME_W - 1);
      lrclk_q <= 1'b1;
      sdata_q <= 1'b0;
      sh_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      slot_q  <= slot_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      sh_q    <= sh_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Sample storage; contents are only read while the count says valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= in_if.in_data;
  end

  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign fifo_level = cnt_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Directed bench for pcm_i2s_tx: one instance with BCLK_DIV=1, one with BCLK_DIV=3.
module tb_pcm_i2s_tx;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en1, en3, clr1, clr3;
  logic       bclk1, lrclk1, sdata1, ovf1, udf1;
  logic       bclk3, lrclk3, sdata3, ovf3, udf3;
  logic [2:0] lvl1, lvl3;

  pcm_i2s_tx_if #(.WIDTH(W)) if1 ();
  pcm_i2s_tx_if #(.WIDTH(W)) if3 ();

  pcm_i2s_tx #(.WIDTH(W), .BCLK_DIV(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .in_if(if1), .clr_flags(clr1),
    .bclk(bclk1), .lrclk(lrclk1), .sdata(sdata1), .fifo_level(lvl1),
    .overflow(ovf1), .underflow(udf1)
  );

  pcm_i2s_tx #(.WIDTH(W), .BCLK_DIV(3), .FIFO_DEPTH(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .in_if(if3), .clr_flags(clr3),
    .bclk(bclk3), .lrclk(lrclk3), .sdata(sdata3), .fifo_level(lvl3),
    .overflow(ovf3), .underflow(udf3)
  );

  int   errors = 0;
  int   checks = 0;
  int   tb_slot;
  bit   fell;
  logic bclk_p;
  int   tog_bad = 0;
  int   max_level = 0;

  // Advance one clk on DUT1 and track bit-clock falls and the expected slot
  task automatic step();
    logic en_prev;
    en_prev = en1 && rst_n;
    @(posedge clk);
    #1;
    fell = en_prev && (bclk_p === 1'b1) && (bclk1 === 1'b0);
    if (en_prev && (bclk1 === bclk_p)) tog_bad++;
    if (fell) tb_slot = (tb_slot == 31) ? 0 : tb_slot + 1;
    if (!en_prev) tb_slot = 31;
    if (int'(lvl1) > max_level) max_level = int'(lvl1);
    bclk_p = bclk1;
  endtask

  task automatic wait_slot(input int s, output bit ok);
    int n;
    n = 0;
    ok = 0;
    while (!ok && n < 200) begin
      step();
      n++;
      if (fell && tb_slot == s) ok = 1;
    end
  endtask

  // Collect the 32 bits of one frame word: slots 1..31 then next slot 0
  task automatic get_frame(output logic [31:0] w, output int lr_bad, output bit ok);
    int n;
    int guard;
    w = '0;
    lr_bad = 0;
    n = 0;
    guard = 0;
    while (n < 32 && guard < 400) begin
      step();
      guard++;
      if (fell && !(n == 0 && tb_slot != 1)) begin
        w = {w[30:0], sdata1};
        if (lrclk1 !== (tb_slot >= 16)) lr_bad++;
        n++;
      end
    end
    ok = (n == 32);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    if1.in_valid = 1'b0;
    if3.in_valid = 1'b0;
    clr1 = 1'b0;
    clr3 = 1'b0;
    en1 = 1'b1;
    en3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tb_slot = 31;
    bclk_p = 1'b0;
    fell = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    en1 = 1'b1; en3 = 1'b1; clr1 = 1'b0; clr3 = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = '0;
    if3.in_valid = 1'b0; if3.in_data = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bclk1 !== 1'b0)  begin errors++; $display("FAIL reset_bclk: got %b want 0", bclk1); end
    checks++; if (lrclk1 !== 1'b1) begin errors++; $display("FAIL reset_lrclk: got %b want 1", lrclk1); end
    checks++; if (sdata1 !== 1'b0) begin errors++; $display("FAIL reset_sdata: got %b want 0", sdata1); end
    checks++; if (lvl1 !== 3'd0)   begin errors++; $display("FAIL reset_level: got %0d want 0", lvl1); end
    checks++; if (ovf1 !== 1'b0)   begin errors++; $display("FAIL reset_overflow: got %b want 0", ovf1); end
    checks++; if (udf1 !== 1'b0)   begin errors++; $display("FAIL reset_underflow: got %b want 0", udf1); end
    checks++; if (lrclk3 !== 1'b1) begin errors++; $display("FAIL reset_lrclk3: got %b want 1", lrclk3); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tb_slot = 31;
    bclk_p = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] w;
    int          lr_bad;
    bit          ok;
    if1.in_valid = 1'b1;
    if1.in_data  = 16'hA5C3;
    step();
    if1.in_valid = 1'b0;
    checks++; if (lvl1 !== 3'd1) begin errors++; $display("FAIL basic_level_push: got %0d want 1", lvl1); end
    checks++; if (bclk1 !== 1'b1) begin errors++; $display("FAIL basic_first_rise: got %b want 1", bclk1); end
    step();
    checks++; if (!fell || lrclk1 !== 1'b0 || sdata1 !== 1'b0)
      begin errors++; $display("FAIL basic_first_fall: fell=%0d lrclk=%b sdata=%b want 1 0 0", fell, lrclk1, sdata1); end
    get_frame(w, lr_bad, ok);
    checks++; if (!ok || w !== 32'hA5C3A5C3) begin errors++; $display("FAIL basic_frame1: got %h want a5c3a5c3 (ok=%0d)", w, ok); end
    checks++; if (lr_bad !== 0) begin errors++; $display("FAIL basic_lrclk1: got %0d bad slots want 0", lr_bad); end
    checks++; if (udf1 !== 1'b0) begin errors++; $display("FAIL basic_no_udf_yet: got %b want 0", udf1); end
    checks++; if (lvl1 !== 3'd0) begin errors++; $display("FAIL basic_level_pop: got %0d want 0", lvl1); end
    get_frame(w, lr_bad, ok);
    checks++; if (!ok || w !== 32'h0) begin errors++; $display("FAIL basic_frame2: got %h want 00000000", w); end
    checks++; if (lr_bad !== 0) begin errors++; $display("FAIL basic_lrclk2: got %0d bad slots want 0", lr_bad); end
    checks++; if (udf1 !== 1'b1) begin errors++; $display("FAIL basic_udf: got %b want 1", udf1); end
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", ovf1); end
  endtask

  task automatic test_steady();
    int lr_tot;
    lr_tot = 0;
    reset_dut();
    max_level = 0;
    tog_bad = 0;
    fork
      begin
        for (int k = 1; k <= 16; k++) begin
          if1.in_valid = 1'b1;
          if1.in_data  = 16'(k);
          @(posedge clk);
          #1;
          if1.in_valid = 1'b0;
          repeat (63) begin
            @(posedge clk);
            #1;
          end
        end
      end
      begin
        for (int k = 1; k <= 16; k++) begin
          logic [31:0] w;
          int          lr_bad;
          bit          ok;
          get_frame(w, lr_bad, ok);
          lr_tot += lr_bad;
          checks++;
          if (!ok || w !== {16'(k), 16'(k)})
            begin errors++; $display("FAIL steady_frame%0d: got %h want %h", k, w, {16'(k), 16'(k)}); end
        end
      end
    join
    checks++; if (lr_tot !== 0) begin errors++; $display("FAIL steady_lrclk: got %0d bad slots want 0", lr_tot); end
    checks++; if (ovf1 !== 1'b0 || udf1 !== 1'b0)
      begin errors++; $display("FAIL steady_flags: got ovf=%b udf=%b want 0 0", ovf1, udf1); end
    checks++; if (max_level > 2 || max_level < 1) begin errors++; $display("FAIL steady_level: got max %0d want 1..2", max_level); end
    checks++; if (tog_bad !== 0) begin errors++; $display("FAIL steady_bclk_toggle: got %0d stalls want 0", tog_bad); end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    int          lr_bad;
    bit          ok;
    reset_dut();
    wait_slot(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_wait: got timeout want slot 5"); end
    for (int k = 1; k <= 6; k++) begin
      if1.in_valid = 1'b1;
      if1.in_data  = 16'(k);
      step();
    end
    if1.in_valid = 1'b0;
    checks++; if (lvl1 !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d want 4", lvl1); end
    checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf1); end
    for (int k = 1; k <= 4; k++) begin
      get_frame(w, lr_bad, ok);
      checks++;
      if (!ok || w !== {16'(k), 16'(k)})
        begin errors++; $display("FAIL ovf_frame%0d: got %h want %h", k, w, {16'(k), 16'(k)}); end
    end
    get_frame(w, lr_bad, ok);
    checks++; if (!ok || w !== 32'h0) begin errors++; $display("FAIL ovf_frame5: got %h want 00000000", w); end
    checks++; if (lvl1 !== 3'd0) begin errors++; $display("FAIL ovf_drained: got %0d want 0", lvl1); end
  endtask

  // Entered just after a slot-0 fall with an empty FIFO and both flags set
  task automatic test_flags();
    step();
    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    checks++; if (udf1 !== 1'b1) begin errors++; $display("FAIL flags_set_wins: got %b want 1", udf1); end
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL flags_ovf_clr: got %b want 0", ovf1); end
    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    checks++; if (udf1 !== 1'b0) begin errors++; $display("FAIL flags_udf_clr: got %b want 0", udf1); end
  endtask

  task automatic test_enable();
    bit ok;
    int n;
    wait_slot(1, ok);
    checks++; if (!ok || udf1 !== 1'b1) begin errors++; $display("FAIL en_pre_udf: got %b want 1 (ok=%0d)", udf1, ok); end
    for (int k = 0; k < 2; k++) begin
      if1.in_valid = 1'b1;
      if1.in_data  = 16'h7000 + 16'(k);
      step();
    end
    if1.in_valid = 1'b0;
    wait_slot(10, ok);
    checks++; if (!ok || lvl1 !== 3'd2) begin errors++; $display("FAIL en_queued: got %0d want 2 (ok=%0d)", lvl1, ok); end
    en1 = 1'b0;
    step();
    checks++; if (bclk1 !== 1'b0)  begin errors++; $display("FAIL en_off_bclk: got %b want 0", bclk1); end
    checks++; if (lrclk1 !== 1'b1) begin errors++; $display("FAIL en_off_lrclk: got %b want 1", lrclk1); end
    checks++; if (sdata1 !== 1'b0) begin errors++; $display("FAIL en_off_sdata: got %b want 0", sdata1); end
    checks++; if (lvl1 !== 3'd0)   begin errors++; $display("FAIL en_off_level: got %0d want 0", lvl1); end
    checks++; if (udf1 !== 1'b1 || ovf1 !== 1'b0)
      begin errors++; $display("FAIL en_off_flags: got udf=%b ovf=%b want 1 0", udf1, ovf1); end
    if1.in_valid = 1'b1;
    if1.in_data  = 16'h1111;
    step();
    if1.in_valid = 1'b0;
    step();
    checks++; if (lvl1 !== 3'd0) begin errors++; $display("FAIL en_off_ignore: got %0d want 0", lvl1); end
    en1 = 1'b1;
    n = 0;
    fell = 0;
    while (!fell && n < 10) begin
      step();
      n++;
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL en_restart_latency: got %0d want 2", n); end
    checks++; if (lrclk1 !== 1'b0 || tb_slot !== 0)
      begin errors++; $display("FAIL en_restart_slot: got lrclk=%b slot=%0d want 0 0", lrclk1, tb_slot); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_slot(1, ok);
    if1.in_valid = 1'b1;
    if1.in_data  = 16'h2222;
    step();
    if1.in_valid = 1'b0;
    wait_slot(20, ok);
    step();
    checks++; if (!ok || lvl1 !== 3'd1 || udf1 !== 1'b1 || bclk1 !== 1'b1)
      begin errors++; $display("FAIL rst_pre: got lvl=%0d udf=%b bclk=%b want 1 1 1", lvl1, udf1, bclk1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bclk1 !== 1'b0 || lrclk1 !== 1'b1 || sdata1 !== 1'b0)
      begin errors++; $display("FAIL rst_async_io: got %b%b%b want 010", bclk1, lrclk1, sdata1); end
    checks++; if (lvl1 !== 3'd0) begin errors++; $display("FAIL rst_async_level: got %0d want 0", lvl1); end
    checks++; if (udf1 !== 1'b0 || ovf1 !== 1'b0)
      begin errors++; $display("FAIL rst_async_flags: got udf=%b ovf=%b want 0 0", udf1, ovf1); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tb_slot = 31;
    bclk_p = 1'b0;
  endtask

  task automatic test_divider();
    logic        b_p, lr_p, sd_p, f3;
    logic [31:0] w;
    int          c, run, run_bad, chg_bad, nfall, slot3, first_c, last_c;
    reset_dut();
    if3.in_valid = 1'b1;
    if3.in_data  = 16'h1234;
    b_p = 1'b0; lr_p = 1'b1; sd_p = 1'b0;
    c = 0; run = 0; run_bad = 0; chg_bad = 0; nfall = 0; slot3 = 31;
    first_c = -1; last_c = -1; w = '0;
    while (nfall < 33 && c < 400) begin
      @(posedge clk);
      #1;
      if3.in_valid = 1'b0;
      c++;
      run++;
      f3 = b_p && !bclk3;
      if (bclk3 !== b_p) begin
        if (run != 3) run_bad++;
        run = 0;
      end
      if ((lrclk3 !== lr_p || sdata3 !== sd_p) && !f3) chg_bad++;
      if (f3) begin
        nfall++;
        slot3 = (slot3 == 31) ? 0 : slot3 + 1;
        if (nfall == 1) first_c = c;
        if (nfall == 33) last_c = c;
        if (nfall >= 2) w = {w[30:0], sdata3};
      end
      b_p = bclk3; lr_p = lrclk3; sd_p = sdata3;
    end
    checks++; if (nfall !== 33) begin errors++; $display("FAIL div_timeout: got %0d falls want 33", nfall); end
    checks++; if (first_c !== 6) begin errors++; $display("FAIL div_first_fall: got %0d want 6", first_c); end
    checks++; if (last_c - first_c !== 192) begin errors++; $display("FAIL div_frame_len: got %0d want 192", last_c - first_c); end
    checks++; if (run_bad !== 0) begin errors++; $display("FAIL div_half_period: got %0d bad runs want 0", run_bad); end
    checks++; if (chg_bad !== 0) begin errors++; $display("FAIL div_change_edge: got %0d off-edge changes want 0", chg_bad); end
    checks++; if (w !== 32'h12341234) begin errors++; $display("FAIL div_frame: got %h want 12341234", w); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_steady();
    test_overflow();
    test_flags();
    test_enable();
    test_reset_mid();
    test_divider();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/pcm_i2s_tx.md
Name: pcm_i2s_tx

Overview:
- Downstream stage of the PDM decimator.
- Accepts one 16-bit PCM sample per decimator valid pulse and buffers it in a small FIFO.
- Serialises each sample as a standard Philips I2S stereo frame (mono sample duplicated to L and R).
- Generates bclk and lrclk from the system clock; it is the audio-codec/DAC-facing output of the microphone path.

Parameters:
- WIDTH, 16, sample width; a frame is 2*WIDTH bit slots.
- BCLK_DIV, 1, clk cycles per bclk half-period (>=1). With BCLK_DIV=1 a frame is 64 clk, matching one decimator output per 64 clk.
- FIFO_DEPTH, 4, sample FIFO entries; power of 2, >=2.

Ports:
- clk  in  1  system clock, same domain as decimator.
- rst_n  in  1  asynchronous reset, active-low.
- en  in  1  transmitter enable.
- in_valid  in  1  single-cycle sample strobe (decimator valid).
- in_data  in  WIDTH  signed PCM sample, sampled when in_valid=1.
- clr_flags  in  1  synchronous clear of overflow/underflow.
- bclk  out  1  I2S bit clock.
- lrclk  out  1  I2S word select; 0=left, 1=right.
- sdata  out  1  I2S serial data, MSB first.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a sample was dropped.
- underflow  out  1  sticky: a frame was sent with zeros.

Behaviour:
- Reset values: bclk=0, lrclk=1, sdata=0, fifo_level=0, overflow=0, underflow=0. Internal slot counter=2*WIDTH-1, divider=0, shift register=0.

Clocking:
- Divider counts clk 0..BCLK_DIV-1; bclk toggles on the terminal count.
- A "fall event" is a toggle while bclk=1.
- All of lrclk, sdata and slot advance occur only on the fall event, so receivers sample on the bclk rising edge.
- On each fall event the slot advances mod 2*WIDTH; lrclk = (new slot >= WIDTH).
- The first fall event after reset release (with en=1) occurs 2*BCLK_DIV clk later and enters slot 0.

Framing (Philips, one-bit delay):
- On the fall event entering slot 1, pop one sample S (or zero on underflow) and form F = {S,S} (2*WIDTH bits).
- Slots 1..2*WIDTH-1 output F[2*WIDTH-1]..F[1].
- Slot 0 of the next frame outputs F[0].
- Net effect: the left MSB appears one bclk after lrclk falls, and the right MSB appears one bclk after lrclk rises.

FIFO:
- Push when in_valid=1 and (not full, or a pop occurs in the same cycle).
- If in_valid=1, the FIFO is full and there is no simultaneous pop: the sample is dropped and overflow is set.
- Pop occurs only at the slot-1 fall event. If the FIFO is empty then, load zeros and set underflow.
- Simultaneous push and pop on an empty FIFO counts as underflow; the pushed sample is stored for the next frame.
- fifo_level updates the cycle after the push/pop.

Flags:
- Sticky until clr_flags=1.
- If clr_flags and a set condition occur in the same cycle, set wins.

Enable:
- en=0 synchronously returns bclk, lrclk, sdata, divider, slot and shift register to reset values and flushes the FIFO (level 0).
- Flags are kept.
- in_valid is ignored while en=0.
- Deasserting en mid-frame truncates the frame immediately.
- Reasserting en restarts exactly as after reset.

Reset:
- Asserting rst_n low mid-frame immediately forces all reset values, including flags.

Test Plan:
- Basic frame: BCLK_DIV=1. Push 0xA5C3 one cycle after reset release, then hold in_valid low. → At slot-1 fall the pop occurs. Over slots 1..31 and next slot 0, sdata on bclk rising edges = A5C3 A5C3 MSB-first. lrclk=0 for slots 0..15 and 1 for 16..31. bclk period is 2 clk. Frame 2 sends zeros and sets underflow=1.
- Steady stream: BCLK_DIV=1, in_valid every 64 clk, incrementing samples 0x0001..0x0010. → No overflow/underflow. fifo_level stays within 0..2. Each frame carries the next sample in order on both L and R.
- Overflow: FIFO_DEPTH=4. Push 6 samples on consecutive cycles before the first slot-1 pop. → fifo_level=4, overflow=1. Frames output samples 1..4; samples 5 and 6 are lost.
- Flag handling: with underflow=1, pulse clr_flags in the same cycle as a new underflow pop. → underflow remains 1. Pulse clr_flags again with no event → underflow=0 next cycle.
- Divider: BCLK_DIV=3. → bclk high 3 clk, low 3 clk. Frame length is 192 clk. lrclk and sdata change only on the clk edge where bclk falls.
- Enable/reset mid-frame: drop en at slot 10 with 2 samples queued. → Next cycle bclk=0, lrclk=1, sdata=0, fifo_level=0, flags unchanged. Re-enable → first fall after 2*BCLK_DIV clk enters slot 0. Repeat with rst_n low at slot 20 → outputs at reset values and flags cleared asynchronously.
